// File: rtl/imem_fetch_arbiter.sv
// Arbitrates CPU and debug fetches onto a single one-cycle-latency instruction ROM.
// Each access walks IDLE -> ADDR (grant) -> DATA (capture), so the port sustains one access per two cycles.
module imem_fetch_arbiter #(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [8:0]  cpu_addr,
    input  logic        cpu_bank,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dbg_req,
    input  logic [8:0]  dbg_addr,
    input  logic        dbg_bank,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] rdata,
    output logic [8:0]  mem_address,
    output logic        mem_signal,
    input  logic [31:0] mem_instr,
    output logic        busy
);

    localparam logic [3:0] MaxBurst = 4'(MAX_CPU_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    state_t      state_q,     state_d;
    owner_t      owner_q,     owner_d;
    logic [3:0]  streak_q,    streak_d;
    logic [8:0]  memAddr_q,   memAddr_d;
    logic        memBank_q,   memBank_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        cpuRvalid_q, cpuRvalid_d;
    logic        dbgRvalid_q, dbgRvalid_d;
    logic        arbitrate;
    logic        dbgWins;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        memAddr_d   = memAddr_q;
        memBank_d   = memBank_q;
        rdata_d     = rdata_q;
        cpuRvalid_d = 1'b0;
        dbgRvalid_d = 1'b0;
        arbitrate   = 1'b0;
        dbgWins     = dbg_req && (!cpu_req || (streak_q == MaxBurst));

        unique case (state_q)
            IDLE: arbitrate = 1'b1;
            ADDR: state_d = DATA;
            DATA: begin
                rdata_d     = mem_instr;
                cpuRvalid_d = (owner_q == OWN_CPU);
                dbgRvalid_d = (owner_q == OWN_DBG);
                state_d     = IDLE;
                arbitrate   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The streak only grows while debug is actually being held off by the CPU.
        if (arbitrate && (cpu_req || dbg_req)) begin
            state_d = ADDR;
            if (dbgWins) begin
                owner_d   = OWN_DBG;
                memAddr_d = dbg_addr;
                memBank_d = dbg_bank;
                streak_d  = 4'd0;
            end else begin
                owner_d   = OWN_CPU;
                memAddr_d = cpu_addr;
                memBank_d = cpu_bank;
                if (dbg_req) begin
                    streak_d = (streak_q < MaxBurst) ? streak_q + 4'd1 : streak_q;
                end else begin
                    streak_d = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            streak_q    <= 4'd0;
            memAddr_q   <= 9'h0;
            memBank_q   <= 1'b0;
            rdata_q     <= 32'h0;
            cpuRvalid_q <= 1'b0;
            dbgRvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            memAddr_q   <= memAddr_d;
            memBank_q   <= memBank_d;
            rdata_q     <= rdata_d;
            cpuRvalid_q <= cpuRvalid_d;
            dbgRvalid_q <= dbgRvalid_d;
        end
    end

    assign cpu_gnt     = (state_q == ADDR) && (owner_q == OWN_CPU);
    assign dbg_gnt     = (state_q == ADDR) && (owner_q == OWN_DBG);
    assign cpu_rvalid  = cpuRvalid_q;
    assign dbg_rvalid  = dbgRvalid_q;
    assign rdata       = rdata_q;
    assign mem_address = memAddr_q;
    assign mem_signal  = memBank_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a transaction-timing model of the arbiter.
module tb_imem_fetch_arbiter;

    localparam int TbMax = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_bank, dbg_req, dbg_bank;
    logic [8:0]  cpu_addr, dbg_addr;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] rdata;
    logic [8:0]  mem_address;
    logic        mem_signal;
    logic [31:0] mem_instr;
    logic        busy;

    imem_fetch_arbiter #(.MAX_CPU_BURST(TbMax)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_bank(dbg_bank),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .mem_address(mem_address), .mem_signal(mem_signal),
        .mem_instr(mem_instr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] memArr [0:1023];

    always @(posedge clk) mem_instr <= memArr[{mem_signal, mem_address}];

    int compared = 0;
    int mismatched = 0;
    bit exclOn = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endfunction

    // Reference model: a grant at edge k shows gnt in cycle k and rvalid/rdata in cycle k+2;
    // the edge right after a grant never arbitrates.
    typedef struct {
        int          cyc;
        int          owner;
        logic [31:0] data;
    } rv_t;

    rv_t         rvQ[$];
    int          edgeNo = 0;
    int          lastGrant = -100;
    int          streakM = 0;
    int          expGntOwner = 0;
    logic [8:0]  expMemAddr = 9'h0;
    logic        expMemBank = 1'b0;
    logic [31:0] expRdata = 32'h0;

    task automatic applyStimulus();
        bit         dbgWins;
        logic [8:0] a;
        logic       b;
        edgeNo++;
        expGntOwner = 0;
        if (reset) begin
            rvQ.delete();
            lastGrant  = -100;
            streakM    = 0;
            expMemAddr = 9'h0;
            expMemBank = 1'b0;
            expRdata   = 32'h0;
        end else if ((edgeNo - lastGrant != 1) && (cpu_req || dbg_req)) begin
            dbgWins = dbg_req && (!cpu_req || streakM == TbMax);
            if (dbgWins) streakM = 0;
            else if (dbg_req) streakM++;
            else streakM = 0;
            a = dbgWins ? dbg_addr : cpu_addr;
            b = dbgWins ? dbg_bank : cpu_bank;
            expMemAddr  = a;
            expMemBank  = b;
            expGntOwner = dbgWins ? 2 : 1;
            rvQ.push_back('{edgeNo + 2, expGntOwner, memArr[{b, a}]});
            lastGrant = edgeNo;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        rv_t r;
        int  eCv = 0;
        int  eDv = 0;
        if (rvQ.size() > 0 && rvQ[0].cyc == edgeNo) begin
            r = rvQ.pop_front();
            eCv = (r.owner == 1);
            eDv = (r.owner == 2);
            expRdata = r.data;
        end
        check($sformatf("model cpu_gnt e%0d", edgeNo), 32'(cpu_gnt), 32'(expGntOwner == 1));
        check($sformatf("model dbg_gnt e%0d", edgeNo), 32'(dbg_gnt), 32'(expGntOwner == 2));
        check($sformatf("model cpu_rvalid e%0d", edgeNo), 32'(cpu_rvalid), 32'(eCv));
        check($sformatf("model dbg_rvalid e%0d", edgeNo), 32'(dbg_rvalid), 32'(eDv));
        check($sformatf("model rdata e%0d", edgeNo), rdata, expRdata);
        check($sformatf("model mem_address e%0d", edgeNo), 32'(mem_address), 32'(expMemAddr));
        check($sformatf("model mem_signal e%0d", edgeNo), 32'(mem_signal), 32'(expMemBank));
        check($sformatf("model busy e%0d", edgeNo), 32'(busy),
              32'((edgeNo - lastGrant >= 0) && (edgeNo - lastGrant <= 1)));
    endtask

    task automatic stepCycle();
        applyStimulus();
        checkOutput();
    endtask

    task automatic applyReset();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exclOn) begin
            check("gnt mutex", 32'(cpu_gnt & dbg_gnt), 32'h0);
            check("rvalid mutex", 32'(cpu_rvalid & dbg_rvalid), 32'h0);
        end
    end

    typedef struct {
        logic        rst, cReq;
        logic [8:0]  cAddr;
        logic        cBank, dReq;
        logic [8:0]  dAddr;
        logic        dBank;
        logic        eCg, eDg, eCv, eDv;
        logic [31:0] eRdata;
        logic [8:0]  eMa;
        logic        eMb, eBusy;
    } vec_t;

    vec_t vecs [10];
    int   gOwn [16];
    int   gEdge [16];
    int   rvE [4];
    logic [31:0] rvD [4];
    int   n, nr;
    bit   found;

    initial begin
        for (int i = 0; i < 1024; i++) memArr[i] = (32'(i) + 32'd1) * 32'h9E3779B9 ^ 32'h5A5A0000;
        memArr[1]   = 32'hDEADBEEF;
        memArr[514] = 32'hCAFEF00D;

        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 9'h0; cpu_bank = 1'b0;
        dbg_req = 1'b0; dbg_addr = 9'h0; dbg_bank = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        9'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 9'd1,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        9'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 9'd1,   1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        9'd1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 9'h1A,  1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        9'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 9'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 9'd1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 9'd2,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 9'd2, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 9'd2, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 9'd2, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 9'd2, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; cpu_req = vecs[i].cReq; cpu_addr = vecs[i].cAddr; cpu_bank = vecs[i].cBank;
            dbg_req = vecs[i].dReq; dbg_addr = vecs[i].dAddr; dbg_bank = vecs[i].dBank;
            stepCycle();
            exclOn = 1'b1;
            check($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].eCg));
            check($sformatf("vec%0d dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].eDg));
            check($sformatf("vec%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].eCv));
            check($sformatf("vec%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].eDv));
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].eRdata);
            check($sformatf("vec%0d mem_address", i), 32'(mem_address), 32'(vecs[i].eMa));
            check($sformatf("vec%0d mem_signal", i), 32'(mem_signal), 32'(vecs[i].eMb));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
        end

        // Continuous contention: debug gets one slot after every TbMax CPU grants.
        applyReset();
        cpu_req = 1'b1; dbg_req = 1'b1; n = 0;
        for (int c = 0; c < 60 && n < 12; c++) begin
            stepCycle();
            if (cpu_gnt || dbg_gnt) begin
                gOwn[n] = dbg_gnt ? 2 : 1; gEdge[n] = edgeNo; n++;
                cpu_addr = 9'($urandom); dbg_addr = 9'($urandom);
            end
        end
        check("contention grants seen", 32'(n), 32'd12);
        for (int i = 0; i < n; i++) begin
            check($sformatf("contention owner %0d", i), 32'(gOwn[i]), 32'(((i % (TbMax + 1)) == TbMax) ? 2 : 1));
            if (i > 0) check($sformatf("contention spacing %0d", i), 32'(gEdge[i] - gEdge[i-1]), 32'd2);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) stepCycle();

        // Back-to-back CPU reads of words 0,1,2.
        cpu_addr = 9'd0; cpu_bank = 1'b0; cpu_req = 1'b1; n = 0; nr = 0;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            stepCycle();
            if (cpu_rvalid) begin rvE[nr] = edgeNo; rvD[nr] = rdata; nr++; end
            if (cpu_gnt) begin
                n++;
                if (n == 3) cpu_req = 1'b0;
                else cpu_addr = 9'(n);
            end
        end
        check("b2b rvalid count", 32'(nr), 32'd3);
        for (int i = 0; i < nr; i++) begin
            check($sformatf("b2b rdata %0d", i), rvD[i], memArr[i]);
            if (i > 0) check($sformatf("b2b spacing %0d", i), 32'(rvE[i] - rvE[i-1]), 32'd2);
        end

        // Reset landing in DATA of a CPU access, after the streak has grown.
        applyReset();
        cpu_req = 1'b1; dbg_req = 1'b1; n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            stepCycle();
            if (cpu_gnt) n++;
        end
        check("pre-abort cpu grants", 32'(n), 32'd3);
        stepCycle();
        check("abort sits in DATA", 32'(busy), 32'd1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        check("abort cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("abort rdata", rdata, 32'h0);
        check("abort mem_address", 32'(mem_address), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            stepCycle();
            if (cpu_gnt || dbg_gnt) begin gOwn[n] = dbg_gnt ? 2 : 1; n++; end
        end
        check("post-abort grants seen", 32'(n), 32'd5);
        for (int i = 0; i < n; i++)
            check($sformatf("post-abort owner %0d", i), 32'(gOwn[i]), 32'((i == 4) ? 2 : 1));
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) stepCycle();

        dbg_addr = 9'd5; dbg_bank = 1'b1; dbg_req = 1'b1; found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            stepCycle();
            if (dbg_gnt) begin found = 1'b1; dbg_req = 1'b0; end
        end
        check("post-abort dbg_gnt seen", 32'(found), 32'd1);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            stepCycle();
            if (dbg_rvalid) begin
                found = 1'b1;
                check("post-abort dbg rdata", rdata, memArr[517]);
                check("post-abort cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            end
        end
        check("post-abort dbg_rvalid seen", 32'(found), 32'd1);

        // Randomized traffic with occasional resets.
        applyReset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            stepCycle();
            if (cpu_gnt) begin
                cpu_req = 1'b0; cpu_addr = 9'($urandom); cpu_bank = 1'($urandom);
                if ($urandom_range(0, 3) == 0) cpu_req = 1'b1;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_addr = 9'($urandom); cpu_bank = 1'($urandom);
            end
            if (dbg_gnt) begin
                dbg_req = 1'b0; dbg_addr = 9'($urandom); dbg_bank = 1'($urandom);
                if ($urandom_range(0, 3) == 0) dbg_req = 1'b1;
            end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1'b1; dbg_addr = 9'($urandom); dbg_bank = 1'($urandom);
            end
        end
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) stepCycle();

        exclOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
